// File: rtl/gate_deadtime_if.sv
// Gate driver bus: enable, bridge requests, dead time, fault in/clear,
// gate drives and latched fault flag.
interface gate_deadtime_if;
  logic       ena;
  logic [7:0] rgz;
  logic [7:0] dtc;
  logic       fli;
  logic       clr;
  logic [7:0] gtz;
  logic       flt;

  modport master (
    output ena, rgz, dtc, fli, clr,
    input  gtz, flt
  );

  modport slave (
    input  ena, rgz, dtc, fli, clr,
    output gtz, flt
  );
endinterface

// File: rtl/gate_deadtime.sv
// Three-phase gate driver with dead-time insertion and fault latch.
// Phase map on rgz/gtz: [5:4]=A{H,L}, [3:2]=B{H,L}, [1:0]=C{H,L}.
// Optional macro SHOOT_FAULT_EN: an illegal (11) request while enabled
// latches the fault; otherwise it is treated as off for that phase only.
module gate_deadtime #(
  parameter int unsigned DT_MIN = 2
) (
  input logic          clk,
  input logic          rst,
  gate_deadtime_if.slave bus
);

  // DT_MIN must be at least 1; a zero setting is floored to 1 so the
  // break-before-make gap can never collapse.
  localparam logic [7:0] DT_FLOOR = (DT_MIN < 1) ? 8'd1 : 8'(DT_MIN);

  // Encoding is {H,L} so each gate pin is a state flop bit directly.
  typedef enum logic [1:0] {
    OFF  = 2'b00,
    ON_L = 2'b01,
    ON_H = 2'b10
  } phase_t;

  logic [5:0] rgz_q;
  logic       fli_q;
  logic       clr_q;
  logic       flt;

  phase_t     state    [3];
  phase_t     state_nx [3];
  logic [7:0] cnt      [3];
  logic [7:0] cnt_nx   [3];

  logic [2:0] req_h;
  logic [2:0] req_l;
  logic [2:0] illegal;
  logic [7:0] td;
  logic       fault_set;
  logic       fault_clr;
  logic       block;

  logic       unused_rgz_hi;
  assign unused_rgz_hi = ^bus.rgz[7:6];

  // Input stage: requests, fault and clear are registered once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgz_q <= '0;
      fli_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      rgz_q <= bus.rgz[5:0];
      fli_q <= bus.fli;
      clr_q <= bus.clr;
    end
  end

  // Request decode, dead-time clamp and fault set/clear conditions.
  always_comb begin
    req_h   = '0;
    req_l   = '0;
    illegal = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      req_h[i]   =  rgz_q[2*i+1] & ~rgz_q[2*i];
      req_l[i]   = ~rgz_q[2*i+1] &  rgz_q[2*i];
      illegal[i] =  rgz_q[2*i+1] &  rgz_q[2*i];
    end
    td = (bus.dtc < DT_FLOOR) ? DT_FLOOR : bus.dtc;
`ifdef SHOOT_FAULT_EN
    fault_set = fli_q | (bus.ena & (|illegal));
`else
    fault_set = fli_q;
`endif
    fault_clr = clr_q & ~fli_q & ~(|illegal);
    block     = ~bus.ena | flt | fault_set;
  end

  // Fault latch; set has priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt <= 1'b0;
    end else if (fault_set) begin
      flt <= 1'b1;
    end else if (fault_clr) begin
      flt <= 1'b0;
    end
  end

  // Per-phase state and dead counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        state[i] <= OFF;
        cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
    end
  end

  // Per-phase next state: leave ON loads the dead time; OFF counts down
  // (even while disabled) and only re-enters ON once the count is zero.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      case (state[i])
        ON_H: begin
          if (!req_h[i] || block) begin
            state_nx[i] = OFF;
            cnt_nx[i]   = td;
          end
        end
        ON_L: begin
          if (!req_l[i] || block) begin
            state_nx[i] = OFF;
            cnt_nx[i]   = td;
          end
        end
        default: begin
          state_nx[i] = OFF;
          if (cnt[i] != '0) begin
            cnt_nx[i] = cnt[i] - 8'd1;
          end else if (!block) begin
            if (req_h[i]) begin
              state_nx[i] = ON_H;
            end else if (req_l[i]) begin
              state_nx[i] = ON_L;
            end
          end
        end
      endcase
    end
  end

  // Gate drives come straight from the state flops.
  always_comb begin
    bus.gtz = {2'b00, state[2], state[1], state[0]};
    bus.flt = flt;
  end

endmodule
